// File: rtl/pwl_eval_stage_if.sv
// pwl_eval_stage_if
//   Bundle of all non-clock signals of the PWL evaluation stage.
//   master : the producer side (comparator + sample source + consumer).
//            It drives data/in_valid/m/c/sat_clr and receives y/out_valid/
//            out_sat/sat_count.
//   slave  : pwl_eval_stage itself.
//   Signals:
//     data      16     sign-magnitude sample
//     in_valid  1      data qualifier
//     m, c      16     sign-magnitude slope/intercept, one cycle after data
//     sat_clr   1      synchronous clear of sat_count
//     y         16     sign-magnitude result
//     out_valid 1      y qualifier
//     out_sat   1      y was saturated
//     sat_count CNT_W  saturating count of saturated valid samples
interface pwl_eval_stage_if #(
  parameter int CNT_W = 16
);
  logic [15:0]      data;
  logic             in_valid;
  logic [15:0]      m;
  logic [15:0]      c;
  logic             sat_clr;
  logic [15:0]      y;
  logic             out_valid;
  logic             out_sat;
  logic [CNT_W-1:0] sat_count;

  modport master (
    output data, in_valid, m, c, sat_clr,
    input  y, out_valid, out_sat, sat_count
  );

  modport slave (
    input  data, in_valid, m, c, sat_clr,
    output y, out_valid, out_sat, sat_count
  );
endinterface

// File: rtl/pwl_eval_stage.sv
// pwl_eval_stage
//   Activation-output stage: evaluates y = m*data + c in 16-bit
//   sign-magnitude fixed point (FRAC fractional bits). data is registered
//   one cycle so it lines up with the (m, c) pair that the region
//   comparator registers one clock after it sees the same sample.
//   Three registered stages from data to y, no backpressure.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-low reset, clears every register
//     bus    pwl_eval_stage_if.slave (data/in_valid/m/c/sat_clr in,
//            y/out_valid/out_sat/sat_count out)
module pwl_eval_stage #(
  parameter int FRAC  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  pwl_eval_stage_if.slave  bus
);

  // Clamp a non-negative product to a 15-bit magnitude; bit 15 = saturated.
  function automatic logic [15:0] sat_mag15(input logic [29:0] v);
    if (|v[29:15]) return {1'b1, 15'h7FFF};
    return {1'b0, v[14:0]};
  endfunction

  // Sign-magnitude add. Returns {sat, sign, mag[14:0]}.
  function automatic logic [16:0] add_sm(input logic        sa,
                                          input logic [14:0] ma,
                                          input logic        sb,
                                          input logic [14:0] mb);
    logic [15:0] sum;
    logic        sat;
    logic        sgn;
    logic [14:0] mag;
    sum = {1'b0, ma} + {1'b0, mb};
    sat = 1'b0;
    if (sa == sb) begin
      sgn = sa;
      if (sum[15]) begin
        sat = 1'b1;
        mag = 15'h7FFF;
      end else begin
        mag = sum[14:0];
      end
    end else if (ma >= mb) begin
      sgn = sa;
      mag = ma - mb;
    end else begin
      sgn = sb;
      mag = mb - ma;
    end
    // A zero result is always +0 so 16'h8000 never leaves the block.
    if (mag == 15'd0) sgn = 1'b0;
    return {sat, sgn, mag};
  endfunction

  logic [15:0]      data_p0;
  logic             vld_p0;
  logic [14:0]      pmag_p1;
  logic             psgn_p1;
  logic             sat_p1;
  logic [15:0]      c_p1;
  logic             vld_p1;
  logic [15:0]      y_p2;
  logic             sat_p2;
  logic             vld_p2;
  logic [CNT_W-1:0] cnt;

  logic [29:0] prod;
  logic [29:0] prod_shr;
  logic [15:0] mul_res;
  logic [16:0] add_res;
  logic        sat_nxt;

  always_comb begin
    prod     = 30'(bus.m[14:0]) * 30'(data_p0[14:0]);
    prod_shr = prod >> FRAC;
    mul_res  = sat_mag15(prod_shr);
    add_res  = add_sm(psgn_p1, pmag_p1, c_p1[15], c_p1[14:0]);
    sat_nxt  = add_res[16] | sat_p1;
  end

  // ---- S0: align data with the comparator's registered (m, c) ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_p0 <= 16'h0000;
      vld_p0  <= 1'b0;
    end else begin
      data_p0 <= bus.data;
      vld_p0  <= bus.in_valid;
    end
  end

  // ---- S1: magnitude multiply, scale, clamp; carry c alongside ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pmag_p1 <= 15'd0;
      psgn_p1 <= 1'b0;
      sat_p1  <= 1'b0;
      c_p1    <= 16'h0000;
      vld_p1  <= 1'b0;
    end else begin
      pmag_p1 <= mul_res[14:0];
      psgn_p1 <= (bus.m[15] ^ data_p0[15]) & (|mul_res[14:0]);
      sat_p1  <= mul_res[15];
      // Negative zero on c is folded to +0 here.
      c_p1    <= (|bus.c[14:0]) ? bus.c : 16'h0000;
      vld_p1  <= vld_p0;
    end
  end

  // ---- S2: sign-magnitude add, output register ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_p2   <= 16'h0000;
      sat_p2 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      y_p2   <= add_res[15:0];
      sat_p2 <= sat_nxt;
      vld_p2 <= vld_p1;
    end
  end

  // Saturation event counter: clear wins over increment, sticks at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (bus.sat_clr) begin
      cnt <= '0;
    end else if (vld_p1 && sat_nxt && (cnt != '1)) begin
      cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.y         = y_p2;
  assign bus.out_valid = vld_p2;
  assign bus.out_sat   = sat_p2;
  assign bus.sat_count = cnt;

endmodule

// File: tb/tb_pwl_eval_stage.sv
// tb_pwl_eval_stage
//   Randomized + directed bench for pwl_eval_stage. Two instances share the
//   stimulus: one with CNT_W=16, one with CNT_W=4 to reach counter saturation.
//   Expected results come from an integer-arithmetic model of y = m*d + c.
module tb_pwl_eval_stage;
  localparam int FRAC = 8;
  localparam int NMAX = 4096;

  logic clk;
  logic reset;

  pwl_eval_stage_if #(.CNT_W(16)) ifa ();
  pwl_eval_stage_if #(.CNT_W(4))  ifb ();

  pwl_eval_stage #(.FRAC(FRAC), .CNT_W(16)) dut  (.clk(clk), .reset(reset), .bus(ifa));
  pwl_eval_stage #(.FRAC(FRAC), .CNT_W(4))  dut4 (.clk(clk), .reset(reset), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_err;

  logic [15:0] sd [NMAX];
  logic [15:0] sm [NMAX];
  logic [15:0] sc [NMAX];
  logic        sv [NMAX];
  int          t;
  int          cnt16;
  int          cnt4;
  logic [15:0] pend_m;
  logic [15:0] pend_c;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: plain signed integer arithmetic. Returns {sat, y}.
  function automatic logic [16:0] ref_eval(input logic [15:0] d, input logic [15:0] m,
                                           input logic [15:0] c);
    longint pm;
    longint pmag;
    longint p;
    longint cv;
    longint s;
    logic   sat;
    logic [15:0] yv;
    pm   = longint'(m[14:0]) * longint'(d[14:0]);
    pm   = pm / (longint'(1) << FRAC);
    sat  = (pm > 32767);
    pmag = sat ? 32767 : pm;
    p    = (m[15] ^ d[15]) ? -pmag : pmag;
    cv   = c[15] ? -longint'(c[14:0]) : longint'(c[14:0]);
    s    = p + cv;
    if (s > 32767)  begin s = 32767;  sat = 1'b1; end
    if (s < -32767) begin s = -32767; sat = 1'b1; end
    if (s < 0) yv = {1'b1, 15'(-s)};
    else       yv = {1'b0, 15'(s)};
    return {sat, yv};
  endfunction

  function automatic logic [15:0] rnd_sm();
    logic [15:0] v;
    case ($urandom_range(0, 4))
      0: v = {1'b0, 15'($urandom_range(0, 32767))};
      1: v = {1'b0, 15'($urandom_range(0, 512))};
      2: v = 16'h7FFF;
      3: v = 16'h0000;
      default: v = {1'b0, 15'($urandom_range(0, 4095))};
    endcase
    if ($urandom_range(0, 1) == 1) v[15] = 1'b1;
    return v;
  endfunction

  // One clock: present sample (d, v) now, its (m, c) next cycle.
  task automatic sample(input logic [15:0] d, input logic v, input logic [15:0] mi,
                        input logic [15:0] ci, input logic clr);
    logic        ev;
    logic [16:0] r;
    @(negedge clk);
    ifa.data = d;  ifa.in_valid = v;  ifa.m = pend_m;  ifa.c = pend_c;  ifa.sat_clr = clr;
    ifb.data = d;  ifb.in_valid = v;  ifb.m = pend_m;  ifb.c = pend_c;  ifb.sat_clr = clr;
    t++;
    sd[t] = d;  sv[t] = v;  sm[t] = mi;  sc[t] = ci;
    pend_m = mi;
    pend_c = ci;
    @(posedge clk);
    #1;
    ev = 1'b0;
    r  = '0;
    if (t >= 3) begin
      ev = sv[t-2];
      r  = ref_eval(sd[t-2], sm[t-2], sc[t-2]);
    end
    if (clr) begin
      cnt16 = 0;
      cnt4  = 0;
    end else if (ev && r[16]) begin
      if (cnt16 < 65535) cnt16++;
      if (cnt4 < 15) cnt4++;
    end
    check_eq("out_valid", ifa.out_valid, ev);
    check_eq("out_valid4", ifb.out_valid, ev);
    if (ev) begin
      check_eq("y", ifa.y, r[15:0]);
      check_eq("out_sat", ifa.out_sat, r[16]);
    end
    check_eq("sat_count", ifa.sat_count, cnt16);
    check_eq("sat_count4", ifb.sat_count, cnt4);
  endtask

  task automatic idle();
    sample(rnd_sm(), 1'b0, rnd_sm(), rnd_sm(), 1'b0);
  endtask

  task automatic model_clear();
    for (int i = 0; i < NMAX; i++) sv[i] = 1'b0;
    t      = 0;
    cnt16  = 0;
    cnt4   = 0;
    pend_m = 16'h0000;
    pend_c = 16'h0000;
  endtask

  task automatic quiet_inputs();
    ifa.data = '0; ifa.in_valid = 1'b0; ifa.m = '0; ifa.c = '0; ifa.sat_clr = 1'b0;
    ifb.data = '0; ifb.in_valid = 1'b0; ifb.m = '0; ifb.c = '0; ifb.sat_clr = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_y"},         ifa.y, 16'h0000);
    check_eq({tag, "_out_valid"}, ifa.out_valid, 1'b0);
    check_eq({tag, "_out_sat"},   ifa.out_sat, 1'b0);
    check_eq({tag, "_sat_count"}, ifa.sat_count, 0);
    check_eq({tag, "_sat_count4"}, ifb.sat_count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    model_clear();
    quiet_inputs();
    reset = 1'b0;
    #1;
    check_zero("rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // 1.5 * 2.0 - 0.5 = 2.5
    sample(16'h0180, 1'b1, 16'h0200, 16'h8080, 1'b0);
    idle(); idle();
    check_eq("tp1_y", ifa.y, 16'h0280);
    check_eq("tp1_vld", ifa.out_valid, 1'b1);
    check_eq("tp1_sat", ifa.out_sat, 1'b0);

    // Multiply saturation, positive then negative.
    sample(16'h7FFF, 1'b1, 16'h7FFF, 16'h0001, 1'b0);
    sample(16'h7FFF, 1'b1, 16'hFFFF, 16'h0000, 1'b0);
    idle();
    check_eq("tp2_y", ifa.y, 16'h7FFF);
    check_eq("tp2_sat", ifa.out_sat, 1'b1);
    check_eq("tp2_cnt", ifa.sat_count, 1);
    idle();
    check_eq("tp2b_y", ifa.y, 16'hFFFF);
    check_eq("tp2b_sat", ifa.out_sat, 1'b1);
    check_eq("tp2b_cnt", ifa.sat_count, 2);

    // Zero results must be +0; negative-zero c acts as +0.
    sample(16'h0100, 1'b1, 16'h8100, 16'h0100, 1'b0);
    sample(16'h0001, 1'b1, 16'h0001, 16'h8000, 1'b0);
    idle();
    check_eq("tp3_y", ifa.y, 16'h0000);
    idle();
    check_eq("tp3b_y", ifa.y, 16'h0000);
    check_eq("tp3b_sat", ifa.out_sat, 1'b0);

    // 20 samples, in_valid drops every 3rd cycle.
    for (int i = 0; i < 20; i++)
      sample(rnd_sm(), (i % 3) != 2, rnd_sm(), rnd_sm(), 1'b0);
    idle(); idle();

    // Random valid pattern with occasional counter clears.
    for (int i = 0; i < 80; i++)
      sample(rnd_sm(), $urandom_range(0, 3) != 0, rnd_sm(), rnd_sm(),
             $urandom_range(0, 15) == 0);
    idle(); idle();

    // Asynchronous reset in the middle of a valid stream.
    for (int i = 0; i < 5; i++)
      sample(16'h7FFF, 1'b1, 16'h7FFF, rnd_sm(), 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_zero("midrst");
    quiet_inputs();
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    repeat (4) idle();

    // Counter saturation (CNT_W=4 holds at 4'hF).
    for (int i = 0; i < 18; i++)
      sample(16'h7FFF, 1'b1, 16'h7FFF, 16'h0000, 1'b0);
    idle(); idle();
    check_eq("hold_cnt4", ifb.sat_count, 4'hF);
    check_eq("hold_cnt16", ifa.sat_count, 18);

    // Clear on the same edge a saturated result arrives.
    sample(16'h7FFF, 1'b1, 16'h7FFF, 16'h0000, 1'b0);
    idle();
    sample(rnd_sm(), 1'b0, rnd_sm(), rnd_sm(), 1'b1);
    check_eq("clr_sat", ifa.out_sat, 1'b1);
    check_eq("clr_cnt16", ifa.sat_count, 0);
    check_eq("clr_cnt4", ifb.sat_count, 0);
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pwl_eval_stage.md
Name: pwl_eval_stage

Overview:
- Downstream neighbour of the 8-breakpoint PWL region comparator, which registers a slope m and intercept c one clock after it samples data.
- This block re-aligns data with that (m, c) pair.
- It evaluates y = m*data + c in 16-bit sign-magnitude fixed point through a registered multiply/add pipeline.
- Outputs: y, a per-sample saturation flag and a saturation event counter. This is the activation-output stage of the Level-1 pipeline.

Parameters:
- FRAC, 8, number of fractional bits in all 16-bit operands (1.0 = 16'h0100 at default); legal range 0..14.
- CNT_W, 16, width of the saturation event counter.

Ports:
- clk  in  1  rising-edge clock, shared with the comparator.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- data  in  16  sign-magnitude sample, presented in the same cycle it is presented to the comparator.
- in_valid  in  1  data qualifier, same cycle as data.
- m  in  16  sign-magnitude slope from the comparator; corresponds to data of the previous cycle.
- c  in  16  sign-magnitude intercept from the comparator; same timing as m.
- sat_clr  in  1  synchronous clear of sat_count.
- y  out  16  sign-magnitude result.
- out_valid  out  1  y qualifier.
- out_sat  out  1  y was saturated (multiply or add stage).
- sat_count  out  CNT_W  number of valid samples with out_sat=1; saturates at all-ones.

Behaviour:
- Reset (reset=0, asynchronous): y=0, out_valid=0, out_sat=0, sat_count=0. All internal pipeline registers clear, valid bits included. A reset mid-stream discards in-flight samples. First out_valid after release: 3 edges after the first post-release in_valid.
- No backpressure; one sample per clock sustained; output order equals input order.
- S0, align register: at edge k, data and in_valid are registered as d0 and v0. m and c valid at edge k+1 pair with d0.
- S1, multiply, at edge k+1:
  - pm = m[14:0]*d0[14:0], a 30-bit product; pms = pm >> FRAC, truncation toward zero.
  - If pms > 32767: pmag=32767 and sat1=1; otherwise pmag=pms and sat1=0.
  - psgn = m[15]^d0[15], forced to 0 when pmag==0.
  - c is registered alongside, with v1=v0.
- S2, add, at edge k+2, result registered into y, out_sat and out_valid=v1:
  - Signs equal: sum = pmag + c_mag as 16 bits. If sum > 32767, mag=32767 and sat2=1. Sign is the common sign.
  - Signs differ: mag = |pmag - c_mag|, with the sign of the larger operand. No saturation is possible.
  - Any zero magnitude yields sign 0; y never outputs 16'h8000.
  - Input 16'h8000 (negative zero) on any operand is treated as +0.
  - out_sat = sat1 | sat2.
- Latency: data at cycle k gives y at edge k+3, i.e. 3 registered stages from data, 2 from m/c.
- When out_valid=0, y and out_sat still update from the pipeline but are don't-care. out_sat is used only when out_valid=1.
- sat_count:
  - Increments on each edge where the S2 result is valid and saturated.
  - sat_clr has priority: that edge sets the counter to 0 and discards any increment.
  - Holds at 2^CNT_W-1, with no wrap.

Test Plan:
- m=16'h0200, c=16'h8080 aligned after data=16'h0180, in_valid=1 -> three edges later y=16'h0280 (2*1.5-0.5=2.5), out_valid=1, out_sat=0.
- m=16'h7FFF, data=16'h7FFF, c=16'h0001 -> y=16'h7FFF, out_sat=1, sat_count 0->1; next sample m=16'hFFFF, data=16'h7FFF -> y=16'hFFFF, out_sat=1.
- m=16'h8100, data=16'h0100, c=16'h0100 -> y=16'h0000 (not 16'h8000). m=16'h0001, data=16'h0001, c=16'h8000 -> y=16'h0000, out_sat=0.
- 20 back-to-back valid samples with in_valid toggling every 3rd cycle -> out_valid pattern delayed exactly 3 edges; every y matches a reference model; no drops or reorder.
- Stream running, reset=0 asynchronously mid-cycle -> y, out_valid, out_sat and sat_count read 0 before the next clk edge; after release no stale out_valid.
- Force sat_count to all-ones using CNT_W=4 and 16 saturating samples -> holds at 4'hF. Assert sat_clr on the same edge as a saturating sample -> counter reads 0.
